// File: rtl/period_meter_pkg.sv
// Shared constants for the period meter: default sizing and FSM state encoding.
package period_meter_pkg;

  // Default counter/result width; the longest measurable period is 2^width-1 cycles.
  localparam int DefCountWidth = 16;

  // Default synchronizer depth for the asynchronous input.
  localparam int DefSyncStages = 2;

  // ARM waits for the first rising edge; MEASURE counts cycles between rising edges.
  localparam logic [0:0] StateArm     = 1'b0;
  localparam logic [0:0] StateMeasure = 1'b1;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous input followed by an edge register.
// Produces one-cycle rise/fall pulses in the clk domain. Reset is active-low.
module sync_edge_detect
  import period_meter_pkg::*;
#(
  parameter int STAGES = DefSyncStages
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] chain_q;
  logic              prev_q;
  logic              sync;

  assign sync = chain_q[STAGES-1];

  // Shift the raw input through the synchronizer and remember the last synchronized value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], async_i};
      prev_q  <= sync;
    end
  end

  assign rise_o = sync & ~prev_q;
  assign fall_o = ~sync & prev_q;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow square wave in clk cycles and
// presents each result on a valid/ready output register. Reset is active-low.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int COUNT_WIDTH = DefCountWidth,
  parameter int SYNC_STAGES = DefSyncStages
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   sig_in,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [COUNT_WIDTH-1:0] period_out,
  output logic [COUNT_WIDTH-1:0] high_out,
  output logic                   timeout,
  output logic                   overrun
);

  localparam logic [COUNT_WIDTH-1:0] CntMax = '1;
  localparam logic [COUNT_WIDTH-1:0] CntOne = COUNT_WIDTH'(1);

  logic                   rise;
  logic                   fall;
  logic                   done;

  logic [0:0]             state_q, state_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0] hi_cap_q, hi_cap_d;
  logic                   timeout_q, timeout_d;
  logic                   valid_q, valid_d;
  logic [COUNT_WIDTH-1:0] period_q, period_d;
  logic [COUNT_WIDTH-1:0] high_q, high_d;
  logic                   overrun_q, overrun_d;

  sync_edge_detect #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .async_i(sig_in),
    .rise_o (rise),
    .fall_o (fall)
  );

  // Counter FSM: a rising edge closes one period and opens the next in the same cycle,
  // so back-to-back periods never lose an edge; saturation abandons the measurement.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_cap_d  = hi_cap_q;
    timeout_d = 1'b0;
    done      = 1'b0;
    if (!en) begin
      state_d  = StateArm;
      cnt_d    = '0;
      hi_cap_d = '0;
    end else if (state_q == StateArm) begin
      cnt_d = '0;
      if (rise) begin
        state_d  = StateMeasure;
        cnt_d    = CntOne;
        hi_cap_d = '0;
      end
    end else begin
      if (rise) begin
        done     = 1'b1;
        cnt_d    = CntOne;
        hi_cap_d = '0;
      end else if (cnt_q == CntMax) begin
        timeout_d = 1'b1;
        state_d   = StateArm;
        cnt_d     = '0;
        hi_cap_d  = '0;
      end else begin
        cnt_d = cnt_q + CntOne;
        if (fall) begin
          hi_cap_d = cnt_q;
        end
      end
    end
  end

  // Output register: load a finished result when the slot is free or being drained,
  // otherwise drop it and latch the sticky overrun flag.
  always_comb begin
    valid_d   = valid_q;
    period_d  = period_q;
    high_d    = high_q;
    overrun_d = overrun_q;
    if (done) begin
      if (!valid_q || out_ready) begin
        valid_d  = 1'b1;
        period_d = cnt_q;
        high_d   = hi_cap_q;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // State and output registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StateArm;
      cnt_q     <= '0;
      hi_cap_q  <= '0;
      timeout_q <= 1'b0;
      valid_q   <= 1'b0;
      period_q  <= '0;
      high_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_cap_q  <= hi_cap_d;
      timeout_q <= timeout_d;
      valid_q   <= valid_d;
      period_q  <= period_d;
      high_q    <= high_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_valid  = valid_q;
  assign period_out = period_q;
  assign high_out   = high_q;
  assign timeout    = timeout_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_period_meter.sv
// Randomized bench for period_meter with a timestamp-based reference model
// and a per-cycle compare process, plus literal checks of key scenarios.
module tb_period_meter;

  localparam int CW   = 6;
  localparam int NS   = 2;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          sig_in = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [CW-1:0] period_out;
  logic [CW-1:0] high_out;
  logic          timeout;
  logic          overrun;

  int checks = 0;
  int failures = 0;
  int tPulses = 0;
  bit randReady = 1'b0;

  period_meter #(
    .COUNT_WIDTH(CW),
    .SYNC_STAGES(NS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sig_in    (sig_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .period_out(period_out),
    .high_out  (high_out),
    .timeout   (timeout),
    .overrun   (overrun)
  );

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  // Reference model state: delayed input history and timestamps of the edges seen.
  bit samp [0:NS+1];
  int cyc;
  bit measuring;
  bit haveFall;
  int riseT;
  int fallT;
  bit mValid;
  bit mOverrun;
  bit mTimeout;
  int mPeriod;
  int mHigh;

  // Reference model: an edge arrives NS cycles after sampling; a period is the
  // distance between two rising-edge timestamps, the high time is fall minus rise.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i <= NS + 1; i++) samp[i] = 1'b0;
      cyc = 0;
      measuring = 1'b0;
      haveFall = 1'b0;
      riseT = 0;
      fallT = 0;
      mValid = 1'b0;
      mOverrun = 1'b0;
      mTimeout = 1'b0;
      mPeriod = 0;
      mHigh = 0;
    end else begin : modelStep
      bit cur, prv, rise, fall, completed;
      int age, per, hi;
      cyc++;
      for (int i = NS + 1; i > 0; i--) samp[i] = samp[i-1];
      samp[0] = sig_in;
      cur = samp[NS];
      prv = samp[NS+1];
      rise = cur && !prv;
      fall = !cur && prv;
      completed = 1'b0;
      per = 0;
      hi = 0;
      mTimeout = 1'b0;
      if (!en) begin
        measuring = 1'b0;
      end else if (measuring) begin
        age = cyc - riseT;
        if (rise) begin
          completed = 1'b1;
          per = age;
          hi = haveFall ? (fallT - riseT) : 0;
          riseT = cyc;
          haveFall = 1'b0;
        end else if (age == MAXC) begin
          mTimeout = 1'b1;
          measuring = 1'b0;
        end else if (fall) begin
          haveFall = 1'b1;
          fallT = cyc;
        end
      end else if (rise) begin
        measuring = 1'b1;
        riseT = cyc;
        haveFall = 1'b0;
      end
      if (completed) begin
        if (!mValid || out_ready) begin
          mValid = 1'b1;
          mPeriod = per;
          mHigh = hi;
        end else begin
          mOverrun = 1'b1;
        end
      end else if (mValid && out_ready) begin
        mValid = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare every cycle, away from the active edge, whenever reset is released.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("out_valid", int'(out_valid), int'(mValid));
      checkOutput("period_out", int'(period_out), mPeriod);
      checkOutput("high_out", int'(high_out), mHigh);
      checkOutput("timeout", int'(timeout), int'(mTimeout));
      checkOutput("overrun", int'(overrun), int'(mOverrun));
      if (timeout) tPulses++;
    end
  end

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst = 1'b0;
    repeat (2) waitCycle();
    rst = 1'b1;
    repeat (2) waitCycle();
  endtask

  // Drive nPeriods of a square wave: high for `high` cycles, low for the rest.
  task automatic applyStimulus(input int period, input int high, input int nPeriods);
    for (int p = 0; p < nPeriods; p++) begin
      for (int c = 0; c < period; c++) begin
        sig_in = (c < high);
        if (randReady) out_ready = 1'($urandom_range(0, 1));
        waitCycle();
      end
    end
  endtask

  initial begin
    // Reset state
    rst = 1'b0;
    #23;
    checkOutput("rst_valid", int'(out_valid), 0);
    checkOutput("rst_period", int'(period_out), 0);
    checkOutput("rst_timeout", int'(timeout), 0);
    rst = 1'b1;
    en = 1'b1;
    out_ready = 1'b1;
    repeat (3) waitCycle();

    // Symmetric 12-cycle stream
    applyStimulus(12, 6, 5);
    checkOutput("p12_period", int'(period_out), 12);
    checkOutput("p12_high", int'(high_out), 6);
    checkOutput("p12_overrun", int'(overrun), 0);

    // Consumer stalled: results held, later ones dropped
    resetDut();
    out_ready = 1'b0;
    applyStimulus(10, 3, 4);
    checkOutput("stall_valid", int'(out_valid), 1);
    checkOutput("stall_period", int'(period_out), 10);
    checkOutput("stall_high", int'(high_out), 3);
    checkOutput("stall_overrun", int'(overrun), 1);
    out_ready = 1'b1;
    applyStimulus(10, 3, 2);
    checkOutput("drain_period", int'(period_out), 10);
    checkOutput("drain_overrun", int'(overrun), 1);

    // Saturation: one rise then a long low phase
    tPulses = 0;
    applyStimulus(MAXC + 10, 2, 1);
    checkOutput("timeout_pulses", tPulses, 1);
    applyStimulus(8, 4, 3);
    checkOutput("after_to_period", int'(period_out), 8);
    checkOutput("after_to_high", int'(high_out), 4);

    // Asynchronous reset between clock edges during a low phase
    out_ready = 1'b0;
    applyStimulus(12, 6, 3);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("arst_valid", int'(out_valid), 0);
    checkOutput("arst_overrun", int'(overrun), 0);
    checkOutput("arst_period", int'(period_out), 0);
    checkOutput("arst_high", int'(high_out), 0);
    #1 rst = 1'b1;
    out_ready = 1'b1;
    applyStimulus(12, 6, 1);
    checkOutput("arst_one_edge_valid", int'(out_valid), 0);
    applyStimulus(12, 6, 2);
    checkOutput("arst_period_after", int'(period_out), 12);

    // Enable dropped for 20 cycles mid-stream
    fork
      applyStimulus(12, 6, 6);
      begin
        repeat (15) waitCycle();
        en = 1'b0;
        repeat (20) waitCycle();
        en = 1'b1;
      end
    join
    checkOutput("en_period", int'(period_out), 12);
    checkOutput("en_high", int'(high_out), 6);

    // Minimum period
    fork
      applyStimulus(2, 1, 20);
      begin
        repeat (15) waitCycle();
        checkOutput("min_period", int'(period_out), 2);
        checkOutput("min_high", int'(high_out), 1);
      end
    join

    // Randomized periods, duty cycles, consumer stalls and enable gaps
    resetDut();
    randReady = 1'b1;
    for (int k = 0; k < 40; k++) begin
      int p;
      int h;
      p = int'($urandom_range(2, 40));
      h = int'($urandom_range(1, p - 1));
      if ($urandom_range(0, 9) == 0) en = 1'b0;
      else en = 1'b1;
      applyStimulus(p, h, int'($urandom_range(1, 3)));
    end
    en = 1'b1;
    applyStimulus(MAXC + 5, 3, 1);
    applyStimulus(7, 2, 3);
    randReady = 1'b0;
    out_ready = 1'b1;
    repeat (10) waitCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
